// File: rtl/vram_pkg.sv
// Shared types and constants for the Wishbone frame-buffer responder.
package vram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        ACK
    } vram_state_t;

    localparam int WORD_BYTES          = 4;
    localparam int DEFAULT_DEPTH_WORDS = 4096;

endpackage

// File: rtl/wb_vram_slave_bram.sv
// Single-port frame-buffer RAM: synchronous read, per-byte write enables.
module wb_vram_slave_bram
    import vram_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH_WORDS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [WORD_BYTES-1:0] we,
    input  logic [AW-1:0]         addr,
    input  logic [31:0]           din,
    output logic [31:0]           dout
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (we[k]) mem[addr][8*k +: 8] <= din[8*k +: 8];
            end
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_vram_slave.sv
// Wishbone classic responder for the video frame buffer.
// CPU writes are accepted only when WB_VRAM_WRITE_EN is defined.
module wb_vram_slave
    import vram_pkg::*;
#(
    parameter logic [31:0] ADR_BASE    = 32'h0000_0000,
    parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int          IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o
);

`ifdef WB_VRAM_WRITE_EN
    localparam bit WRITE_EN = 1'b1;
`else
    localparam bit WRITE_EN = 1'b0;
`endif

    vram_state_t state;

    logic        below;
    logic [31:0] off;
    logic        hit;
    logic        req;
    logic        rd_hit;
    logic        wr_hit;
    logic [31:0] ram_dout;

    // Borrow out of the subtraction flags addresses below the window.
    assign {below, off} = {1'b0, wb_adr_i} - {1'b0, ADR_BASE};

    assign hit = !below
              && ({2'b00, off[31:2]} < 32'(DEPTH_WORDS))
              && (off[1:0] == 2'b00);

    assign req    = (state == IDLE) && wb_cyc_i && wb_stb_i;
    assign rd_hit = req && hit && !wb_we_i;
    assign wr_hit = req && hit && wb_we_i && WRITE_EN;

    wb_vram_slave_bram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (IDX_W)
    ) u_bram (
        .clk  (wb_clk_i),
        .en   (rd_hit || wr_hit),
        .we   ({WORD_BYTES{wr_hit}} & wb_sel_i),
        .addr (off[IDX_W+1:2]),
        .din  (wb_dat_i),
        .dout (ram_dout)
    );

    assign wb_rty_o = 1'b0;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        if (!hit || (wb_we_i && !WRITE_EN)) begin
                            wb_err_o <= 1'b1;
                            state    <= ACK;
                        end else if (wb_we_i) begin
                            wb_ack_o <= 1'b1;
                            state    <= ACK;
                        end else begin
                            state    <= RD;
                        end
                    end
                end
                RD: begin
                    // A dropped cyc abandons the beat silently.
                    if (wb_cyc_i) begin
                        wb_dat_o <= ram_dout;
                        wb_ack_o <= 1'b1;
                        state    <= ACK;
                    end else begin
                        state    <= IDLE;
                    end
                end
                ACK: begin
                    wb_ack_o <= 1'b0;
                    wb_err_o <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_vram_slave.sv
// Directed bench for wb_vram_slave: vector table plus burst/abort/reset sequences.
module tb_wb_vram_slave;
    import vram_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          DW   = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] adr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] wdat = '0;
    logic [31:0] dat_o;
    logic        ack;
    logic        err;
    logic        rty;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_vram_slave #(
        .ADR_BASE    (BASE),
        .DEPTH_WORDS (DW)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_sel_i (sel),
        .wb_dat_i (wdat),
        .wb_dat_o (dat_o),
        .wb_ack_o (ack),
        .wb_err_o (err),
        .wb_rty_o (rty)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        int          exp_ack;
        int          exp_err;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t        vecs[13];
    logic [31:0] model[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a,
                                input logic [3:0] s, input logic [31:0] d,
                                input int ea, input int ee,
                                input logic cd, input logic [31:0] ed);
        vec_t v;
        v.we = w; v.adr = a; v.sel = s; v.wdat = d;
        v.exp_ack = ea; v.exp_err = ee;
        v.chk_dat = cd; v.exp_dat = ed;
        return v;
    endfunction

    task automatic do_beat(input vec_t v, output int na, output int ne,
                           output logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = v.we;
        adr = v.adr; sel = v.sel; wdat = v.wdat;
        na = 0; ne = 0; d = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ack) begin na++; d = dat_o; end
            if (err) ne++;
            if (ack || err) begin cyc = 1'b0; stb = 1'b0; we = 1'b0; end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        int          na, ne, beat, last_ack_cyc;
        logic [31:0] d;
        logic [31:0] w3;
        int          wr_ack, wr_err;

        for (int i = 0; i < DW; i++) dut.u_bram.mem[i] = '0;
        for (int i = 0; i < 8; i++) model[i] = 32'hC0DE_0000 | 32'(i);
        model[3] = 32'hFFFF_FFFF;
        model[5] = 32'hA5A5_0F0F;
        for (int i = 0; i < 8; i++) dut.u_bram.mem[i] = model[i];
        dut.u_bram.mem[DW-1] = 32'hDEAD_BEEF;

`ifdef WB_VRAM_WRITE_EN
        w3 = 32'hFF22_FF44; wr_ack = 1; wr_err = 0;
`else
        w3 = 32'hFFFF_FFFF; wr_ack = 0; wr_err = 1;
`endif

        // Reset held with a live request
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; adr = BASE + 20;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ack", {31'b0, ack}, 32'd0);
            chk("rst_err", {31'b0, err}, 32'd0);
            chk("rst_dat", dat_o, 32'd0);
        end
        chk("rty_tied", {31'b0, rty}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_no_ack", {30'b0, ack, err}, 32'd0);
        stb = 1'b0;
        tick();
        chk("post_rst_ack", {31'b0, ack}, 32'd1);
        chk("post_rst_dat", dat_o, 32'hA5A5_0F0F);
        cyc = 1'b0;
        tick();
        chk("post_rst_ack_drop", {31'b0, ack}, 32'd0);
        tick();

        // Eight-beat burst with stb held throughout
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
        beat = 0; last_ack_cyc = 0; ne = 0;
        for (int c = 1; c <= 40 && beat < 8; c++) begin
            tick();
            if (err) ne++;
            if (ack) begin
                chk($sformatf("burst_dat%0d", beat), dat_o, model[beat]);
                if (beat > 0)
                    chk($sformatf("burst_gap%0d", beat),
                        32'(c - last_ack_cyc), 32'd3);
                last_ack_cyc = c;
                beat++;
                adr = adr + 32'd4;
                if (beat == 8) begin cyc = 1'b0; stb = 1'b0; end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        chk("burst_beats", 32'(beat), 32'd8);
        chk("burst_no_err", 32'(ne), 32'd0);
        tick();
        chk("burst_no_extra_ack", {31'b0, ack}, 32'd0);
        tick();
        tick();

        // Master abandons a read in the cycle after the sample
        cyc = 1'b1; stb = 1'b1; adr = BASE + 24;
        tick();
        cyc = 1'b0; stb = 1'b0;
        na = 0; ne = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ack) na++;
            if (err) ne++;
        end
        chk("abort_no_ack", 32'(na), 32'd0);
        chk("abort_no_err", 32'(ne), 32'd0);
        chk("abort_dat_held", dat_o, model[7]);
        do_beat(mk(1'b0, BASE + 24, 4'hF, 0, 1, 0, 1'b1, model[6]), na, ne, d);
        chk("abort_next_ack", 32'(na), 32'd1);
        chk("abort_next_dat", d, model[6]);

        // Single-beat vector table
        vecs[0]  = mk(1'b0, BASE + 20,        4'hF, 0, 1, 0, 1'b1, 32'hA5A5_0F0F);
        vecs[1]  = mk(1'b0, BASE,             4'hF, 0, 1, 0, 1'b1, 32'hC0DE_0000);
        vecs[2]  = mk(1'b0, BASE + 4*(DW-1),  4'hF, 0, 1, 0, 1'b1, 32'hDEAD_BEEF);
        vecs[3]  = mk(1'b0, BASE + 4*DW,      4'hF, 0, 0, 1, 1'b0, 0);
        vecs[4]  = mk(1'b0, BASE + 2,         4'hF, 0, 0, 1, 1'b0, 0);
        vecs[5]  = mk(1'b0, BASE - 4,         4'hF, 0, 0, 1, 1'b0, 0);
        vecs[6]  = mk(1'b0, BASE + 20,        4'hF, 0, 1, 0, 1'b1, 32'hA5A5_0F0F);
        vecs[7]  = mk(1'b1, BASE + 12, 4'b0101, 32'h1122_3344,
                      wr_ack, wr_err, 1'b0, 0);
        vecs[8]  = mk(1'b0, BASE + 12,        4'hF, 0, 1, 0, 1'b1, w3);
        vecs[9]  = mk(1'b1, BASE + 12, 4'b0000, 32'h0000_0000,
                      wr_ack, wr_err, 1'b0, 0);
        vecs[10] = mk(1'b0, BASE + 12,        4'hF, 0, 1, 0, 1'b1, w3);
        vecs[11] = mk(1'b1, BASE + 4*DW, 4'hF, 32'h1234_5678, 0, 1, 1'b0, 0);
        vecs[12] = mk(1'b0, BASE,             4'hF, 0, 1, 0, 1'b1, 32'hC0DE_0000);

        for (int i = 0; i < 13; i++) begin
            do_beat(vecs[i], na, ne, d);
            chk($sformatf("v%0d_acks", i), 32'(na), 32'(vecs[i].exp_ack));
            chk($sformatf("v%0d_errs", i), 32'(ne), 32'(vecs[i].exp_err));
            if (vecs[i].chk_dat)
                chk($sformatf("v%0d_dat", i), d, vecs[i].exp_dat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
